// File: rtl/mult_hazard_scheduler_if.sv
// mult_hazard_scheduler_if: ID/EX hazard inputs and pipeline-control outputs of the stall scheduler
interface mult_hazard_scheduler_if #(parameter int CNT_W = 32);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ex_valid;
  logic             ex_mem_read;
  logic             ex_is_mult;
  logic [4:0]       ex_rd;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_bubble;
  logic             id_ex_hold;
  logic             ex_mem_bubble;
  logic             mult_start;
  logic             mult_busy;
  logic [CNT_W-1:0] stall_cycles;
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_valid, ex_mem_read, ex_is_mult, ex_rd,
    input  pc_write, if_id_write, id_ex_bubble, id_ex_hold, ex_mem_bubble,
    input  mult_start, mult_busy, stall_cycles
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_valid, ex_mem_read, ex_is_mult, ex_rd,
    output pc_write, if_id_write, id_ex_bubble, id_ex_hold, ex_mem_bubble,
    output mult_start, mult_busy, stall_cycles
  );
endinterface

// File: rtl/mult_hazard_scheduler.sv
// mult_hazard_scheduler: freezes the front end during multi-cycle MULs, bubbles load-use hazards, counts stalls
module mult_hazard_scheduler #(
  parameter int MULT_LAT = 3,
  parameter int CNT_W    = 32
) (
  input logic clk,
  input logic rst,
  mult_hazard_scheduler_if.slave mhs
);
  typedef enum logic {RUN, MUL_WAIT} state_e;
  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             mul_hit, lu_hit, freeze, lu_stall, pc_w;
  always_comb begin
    mul_hit  = state_q == RUN && mhs.ex_valid && mhs.ex_is_mult;
    lu_hit   = mhs.ex_valid && mhs.ex_mem_read && !mhs.ex_is_mult && mhs.ex_rd != 5'd0 && mhs.id_valid &&
               ((mhs.id_use_rs1 && mhs.id_rs1 == mhs.ex_rd) || (mhs.id_use_rs2 && mhs.id_rs2 == mhs.ex_rd));
    freeze   = mul_hit || (state_q == MUL_WAIT && cnt_q != 4'd0);
    // load-use only matters in RUN and yields to a MUL entering EX
    lu_stall = state_q == RUN && !mul_hit && lu_hit;
    pc_w     = !rst && !freeze && !lu_stall;
    state_d  = mul_hit ? MUL_WAIT : (state_q == MUL_WAIT && cnt_q == 4'd0) ? RUN : state_q;
    cnt_d    = mul_hit ? 4'(MULT_LAT - 2) : freeze ? cnt_q - 4'd1 : cnt_q;
    stall_d  = (!pc_w && stall_q != '1) ? stall_q + 1'b1 : stall_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end
  assign mhs.pc_write      = pc_w;
  assign mhs.if_id_write   = pc_w;
  assign mhs.id_ex_bubble  = rst || lu_stall;
  assign mhs.id_ex_hold    = !rst && freeze;
  assign mhs.ex_mem_bubble = rst || freeze;
  assign mhs.mult_start    = !rst && mul_hit;
  assign mhs.mult_busy     = !rst && freeze;
  assign mhs.stall_cycles  = stall_q;
endmodule

// File: tb/tb_mult_hazard_scheduler.sv
// tb_mult_hazard_scheduler: directed and random checks of two scheduler configurations against a cycle model
module tb_mult_hazard_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mult_hazard_scheduler_if #(.CNT_W(32)) a();
  mult_hazard_scheduler_if #(.CNT_W(4))  b();
  mult_hazard_scheduler #(.MULT_LAT(3), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .mhs(a.slave));
  mult_hazard_scheduler #(.MULT_LAT(2), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .mhs(b.slave));
  assign b.id_valid    = a.id_valid;
  assign b.id_rs1      = a.id_rs1;
  assign b.id_rs2      = a.id_rs2;
  assign b.id_use_rs1  = a.id_use_rs1;
  assign b.id_use_rs2  = a.id_use_rs2;
  assign b.ex_valid    = a.ex_valid;
  assign b.ex_mem_read = a.ex_mem_read;
  assign b.ex_is_mult  = a.ex_is_mult;
  assign b.ex_rd       = a.ex_rd;
  int passed = 0;
  int total  = 0;
  bit en = 1'b0;
  int left[2] = '{0, 0};
  longint cnt[2] = '{0, 0};
  localparam int     LAT[2]  = '{3, 2};
  localparam longint MAXC[2] = '{64'hFFFF_FFFF, 15};
  typedef struct packed {logic pc, ifid, bub, hold, exb, start, busy;} exp_t;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  // left = cycles the current MUL still occupies EX; the last of them is the unfrozen exit cycle
  function automatic exp_t model(input int l);
    exp_t e;
    logic hit, lu;
    e   = '0;
    hit = a.ex_valid && a.ex_is_mult;
    lu  = a.ex_valid && a.ex_mem_read && !a.ex_is_mult && a.ex_rd != 0 && a.id_valid &&
          ((a.id_use_rs1 && a.id_rs1 == a.ex_rd) || (a.id_use_rs2 && a.id_rs2 == a.ex_rd));
    if (rst) begin e.bub = 1; e.exb = 1; end
    else if (l == 0 && hit) begin e.start = 1; e.busy = 1; e.hold = 1; e.exb = 1; end
    else if (l > 1) begin e.busy = 1; e.hold = 1; e.exb = 1; end
    else if (l == 0 && lu) e.bub = 1;
    else begin e.pc = 1; e.ifid = 1; end
    return e;
  endfunction
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      e = model(left[i]);
      if (rst) begin
        left[i] = 0;
        cnt[i]  = 0;
      end else begin
        if (!e.pc && cnt[i] < MAXC[i]) cnt[i]++;
        if (e.start) left[i] = LAT[i] - 1;
        else if (left[i] > 0) left[i]--;
      end
    end
  always @(negedge clk)
    if (en) begin
      chk("outs_a", {a.pc_write, a.if_id_write, a.id_ex_bubble, a.id_ex_hold, a.ex_mem_bubble, a.mult_start, a.mult_busy}, model(left[0]));
      chk("outs_b", {b.pc_write, b.if_id_write, b.id_ex_bubble, b.id_ex_hold, b.ex_mem_bubble, b.mult_start, b.mult_busy}, model(left[1]));
      chk("stall_a", 64'(a.stall_cycles), cnt[0]);
      chk("stall_b", 64'(b.stall_cycles), cnt[1]);
    end
  task automatic go();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    a.id_valid = 0; a.id_rs1 = 0; a.id_rs2 = 0; a.id_use_rs1 = 0; a.id_use_rs2 = 0;
    a.ex_valid = 0; a.ex_mem_read = 0; a.ex_is_mult = 0; a.ex_rd = 0;
  endtask
  task automatic load_use(input logic [4:0] rd);
    idle();
    a.ex_valid = 1; a.ex_mem_read = 1; a.ex_rd = rd;
    a.id_valid = 1; a.id_rs1 = rd; a.id_use_rs1 = 1;
  endtask
  initial begin
    idle();
    rst = 1;
    go();
    en = 1;
    @(negedge clk);
    chk("rst_pc", a.pc_write, 0);
    chk("rst_bub", a.id_ex_bubble, 1);
    chk("rst_stall", a.stall_cycles, 0);
    go();
    rst = 0;
    @(negedge clk);
    chk("post_rst_pc", a.pc_write, 1);
    go();
    load_use(5'd5);
    @(negedge clk);
    chk("lu_pc", a.pc_write, 0);
    chk("lu_bub", a.id_ex_bubble, 1);
    go();
    idle();
    @(negedge clk);
    chk("lu_release", a.pc_write, 1);
    chk("lu_stall_cnt", a.stall_cycles, 1);
    go();
    load_use(5'd7);
    a.ex_is_mult = 1; a.id_rs2 = 5'd7; a.id_use_rs2 = 1;
    @(negedge clk);
    chk("mul_t0_start", a.mult_start, 1);
    chk("mul_t0_busy", a.mult_busy, 1);
    chk("mul_t0_bub", a.id_ex_bubble, 0);
    go();
    @(negedge clk);
    chk("mul_t1_start", a.mult_start, 0);
    chk("mul_t1_busy", a.mult_busy, 1);
    chk("mul_t1_bub", a.id_ex_bubble, 0);
    go();
    @(negedge clk);
    chk("mul_t2_pc", a.pc_write, 1);
    chk("mul_t2_start", a.mult_start, 0);
    go();
    idle();
    @(negedge clk);
    chk("mul_stall_cnt", a.stall_cycles, 3);
    go();
    a.ex_valid = 1; a.ex_is_mult = 1;
    go();
    rst = 1;
    go();
    rst = 0;
    idle();
    @(negedge clk);
    chk("mid_rst_busy", a.mult_busy, 0);
    chk("mid_rst_start", a.mult_start, 0);
    chk("mid_rst_pc", a.pc_write, 1);
    go();
    load_use(5'd0);
    @(negedge clk);
    chk("x0_pc", a.pc_write, 1);
    go();
    load_use(5'd9);
    repeat (20) go();
    idle();
    @(negedge clk);
    chk("sat_b", b.stall_cycles, 15);
    chk("nosat_a", a.stall_cycles, 20);
    go();
    for (int n = 0; n < 3000; n++) begin
      rst           = $urandom_range(63) == 0;
      a.ex_valid    = 1'($urandom);
      a.ex_is_mult  = $urandom_range(3) == 0;
      a.ex_mem_read = 1'($urandom);
      a.ex_rd       = 5'($urandom_range(3));
      a.id_valid    = 1'($urandom);
      a.id_rs1      = 5'($urandom_range(3));
      a.id_rs2      = 5'($urandom_range(3));
      a.id_use_rs1  = 1'($urandom);
      a.id_use_rs2  = 1'($urandom);
      go();
    end
    rst = 0;
    idle();
    go();
    en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
